// File: rtl/burst_ram_responder_pkg.sv
// Shared definitions for the cache-to-SDRAM burst interface.
// Used by the burst RAM responder and by the cache controller on the other side.
//   - default geometry/latency constants
//   - rw encoding (RW_READ / RW_WRITE)
//   - responder FSM state encoding
//   - offset width helper
package burst_ram_responder_pkg;

  localparam int unsigned DEF_ADDR_W    = 14;
  localparam int unsigned DEF_BURST_LEN = 32;
  localparam int unsigned DEF_ACT_LAT   = 3;
  localparam int unsigned DEF_WRITE_LAT = 2;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  typedef enum logic [2:0] {
    StIdle,
    StAct,
    StBurst,
    StWdrain,
    StDone,
    StWaitRel
  } state_e;

  // Bits needed to index one beat inside a page. BURST_LEN >= 2 is assumed.
  function automatic int unsigned off_width(input int unsigned burst_len);
    return (burst_len > 1) ? $clog2(burst_len) : 1;
  endfunction

endpackage

// File: rtl/burst_ram_responder_if.sv
// Cache-to-SDRAM burst bus.
//   master : cache controller, drives ce/address/rw_req/rw/write_data
//   slave  : responder, drives read_data/data_bursting/xfer_done
interface burst_ram_responder_if;

  logic        ce;
  logic [31:0] address;
  logic        rw_req;
  logic        rw;
  logic [15:0] write_data;
  logic [15:0] read_data;
  logic        data_bursting;
  logic        xfer_done;

  modport master (
    output ce,
    output address,
    output rw_req,
    output rw,
    output write_data,
    input  read_data,
    input  data_bursting,
    input  xfer_done
  );

  modport slave (
    input  ce,
    input  address,
    input  rw_req,
    input  rw,
    input  write_data,
    output read_data,
    output data_bursting,
    output xfer_done
  );

endinterface

// File: rtl/burst_ram_mem.sv
// Single-port synchronous RAM, 16 bits x 2^ADDR_W, read-first, 1-cycle registered read.
// No reset: contents and read register power up undefined.
//   clk   : clock
//   we    : write enable
//   addr  : halfword address
//   wdata : write data
//   rdata : read data, valid the cycle after addr is presented
module burst_ram_mem #(
  parameter int unsigned ADDR_W = 14
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [15:0]       wdata,
  output logic [15:0]       rdata
);

  logic [15:0] mem_q [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
    rdata <= mem_q[addr];
  end

endmodule

// File: rtl/burst_ram_responder.sv
// Responder for page-sized read/write bursts, backed by on-chip block RAM.
// One request = one burst of BURST_LEN halfwords within a page aligned to BURST_LEN*2 bytes.
//   clk    : clock, rising edge
//   reset  : asynchronous reset, active high (RAM contents are kept)
//   bus    : burst bus, slave side (ce, address, rw_req, rw, write_data in;
//            read_data, data_bursting, xfer_done out)
module burst_ram_responder
  import burst_ram_responder_pkg::*;
#(
  parameter int unsigned ADDR_W    = DEF_ADDR_W,
  parameter int unsigned BURST_LEN = DEF_BURST_LEN,
  parameter int unsigned ACT_LAT   = DEF_ACT_LAT,
  parameter int unsigned WRITE_LAT = DEF_WRITE_LAT
) (
  input  logic                 clk,
  input  logic                 reset,
  burst_ram_responder_if.slave bus
);

  localparam int unsigned OFF_W       = off_width(BURST_LEN);
  localparam int unsigned PAGE_W      = ADDR_W - OFF_W;
  localparam int unsigned CNT_W       = (OFF_W > 4) ? OFF_W : 4;
  localparam int unsigned WDRAIN_LAST = (WRITE_LAT > 0) ? WRITE_LAT - 1 : 0;

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [PAGE_W-1:0]  page_q;
  logic               rw_q;
  logic               data_bursting_q;
  logic               xfer_done_q;
  logic [15:0]        rd_hold_q;

  logic               wr_en;
  logic [OFF_W-1:0]   wr_off;
  logic [OFF_W-1:0]   rd_off;
  logic [ADDR_W-1:0]  ram_addr;
  logic [15:0]        ram_rdata;
  logic               rd_beat;

  // Only the page number of the request address matters.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.address[31:ADDR_W+1], bus.address[OFF_W:0]};

  // Control FSM; cnt_q counts activation cycles, then beats, then drain cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= StIdle;
      cnt_q           <= '0;
      page_q          <= '0;
      rw_q            <= RW_READ;
      data_bursting_q <= 1'b0;
      xfer_done_q     <= 1'b0;
    end else begin
      xfer_done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (bus.rw_req && bus.ce) begin
            page_q  <= bus.address[ADDR_W:OFF_W+1];
            rw_q    <= bus.rw;
            cnt_q   <= '0;
            state_q <= StAct;
          end
        end
        StAct: begin
          if (cnt_q == CNT_W'(ACT_LAT - 1)) begin
            cnt_q           <= '0;
            data_bursting_q <= 1'b1;
            state_q         <= StBurst;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StBurst: begin
          if (cnt_q == CNT_W'(BURST_LEN - 1)) begin
            cnt_q           <= '0;
            data_bursting_q <= 1'b0;
            if (rw_q == RW_WRITE && WRITE_LAT > 0) begin
              state_q <= StWdrain;
            end else begin
              xfer_done_q <= 1'b1;
              state_q     <= StDone;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StWdrain: begin
          if (cnt_q == CNT_W'(WDRAIN_LAST)) begin
            cnt_q       <= '0;
            xfer_done_q <= 1'b1;
            state_q     <= StDone;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StDone: begin
          state_q <= StWaitRel;
        end
        StWaitRel: begin
          if (!bus.rw_req) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Write path: beat k is committed WRITE_LAT cycles after its burst pulse.
  if (WRITE_LAT == 0) begin : g_wr_direct
    assign wr_en  = data_bursting_q && (rw_q == RW_WRITE);
    assign wr_off = cnt_q[OFF_W-1:0];
  end else begin : g_wr_pipe
    logic [WRITE_LAT-1:0] wp_vld_q;
    logic [OFF_W-1:0]     wp_off_q [WRITE_LAT];

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        wp_vld_q <= '0;
        for (int i = 0; i < int'(WRITE_LAT); i++) begin
          wp_off_q[i] <= '0;
        end
      end else begin
        wp_vld_q[0] <= data_bursting_q && (rw_q == RW_WRITE);
        wp_off_q[0] <= cnt_q[OFF_W-1:0];
        for (int i = 1; i < int'(WRITE_LAT); i++) begin
          wp_vld_q[i] <= wp_vld_q[i-1];
          wp_off_q[i] <= wp_off_q[i-1];
        end
      end
    end

    assign wr_en  = wp_vld_q[WRITE_LAT-1];
    assign wr_off = wp_off_q[WRITE_LAT-1];
  end

  // Read path: RAM is addressed one beat ahead. During ACT this is beat 0, so the
  // last ACT cycle presents beat 0; in BURST beat k presents k+1 (wraps in the page,
  // the final over-read is discarded).
  always_comb begin
    rd_off = '0;
    if (state_q == StBurst) begin
      rd_off = cnt_q[OFF_W-1:0] + OFF_W'(1);
    end
  end

  assign ram_addr = wr_en ? {page_q, wr_off} : {page_q, rd_off};

  burst_ram_mem #(
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .we    (wr_en),
    .addr  (ram_addr),
    .wdata (bus.write_data),
    .rdata (ram_rdata)
  );

  // RAM has no reset, so a resettable hold register keeps the last beat outside
  // read bursts and gives read_data its reset value of 0.
  assign rd_beat = data_bursting_q && (rw_q == RW_READ);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_hold_q <= '0;
    end else if (rd_beat) begin
      rd_hold_q <= ram_rdata;
    end
  end

  assign bus.read_data     = rd_beat ? ram_rdata : rd_hold_q;
  assign bus.data_bursting = data_bursting_q;
  assign bus.xfer_done     = xfer_done_q;

endmodule

// File: tb/tb_burst_ram_responder.sv
module tb_burst_ram_responder;
  import burst_ram_responder_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  burst_ram_responder_if a_if ();
  burst_ram_responder_if b_if ();

  burst_ram_responder #(
    .ADDR_W    (14),
    .BURST_LEN (32),
    .ACT_LAT   (3),
    .WRITE_LAT (2)
  ) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (a_if.slave)
  );

  burst_ram_responder #(
    .ADDR_W    (10),
    .BURST_LEN (8),
    .ACT_LAT   (1),
    .WRITE_LAT (0)
  ) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (b_if.slave)
  );

  // Shared stimulus, steered to one DUT by sel_b.
  logic        sel_b = 1'b0;
  logic        drv_ce = 1'b0;
  logic        drv_req = 1'b0;
  logic        drv_rw = RW_READ;
  logic [31:0] drv_addr = '0;
  logic [15:0] drv_wdata = '0;

  assign a_if.ce         = drv_ce & ~sel_b;
  assign a_if.rw_req     = drv_req & ~sel_b;
  assign a_if.rw         = drv_rw;
  assign a_if.address    = drv_addr;
  assign a_if.write_data = drv_wdata;
  assign b_if.ce         = drv_ce & sel_b;
  assign b_if.rw_req     = drv_req & sel_b;
  assign b_if.rw         = drv_rw;
  assign b_if.address    = drv_addr;
  assign b_if.write_data = drv_wdata;

  logic        obs_burst;
  logic        obs_done;
  logic [15:0] obs_rdata;
  assign obs_burst = sel_b ? b_if.data_bursting : a_if.data_bursting;
  assign obs_done  = sel_b ? b_if.xfer_done : a_if.xfer_done;
  assign obs_rdata = sel_b ? b_if.read_data : a_if.read_data;

  int n_checks = 0;
  int n_fail = 0;

  logic [15:0] exp_q [$];
  logic [15:0] beats [32];

  typedef struct {
    logic        rw;
    logic [31:0] addr;
    logic [15:0] base;      // write data base, or expected read data base
    int          exp_done;  // xfer_done cycle relative to accept
    int          hold;      // cycles rw_req stays high after xfer_done
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Write beat j is presented wlat cycles after its pulse; garbage elsewhere.
  task automatic drive_wdata(input logic rw, input int cyc, input int act_lat, input int wlat,
                             input int blen);
    int j;
    j = cyc - (1 + act_lat) - wlat;
    if (rw == RW_WRITE && j >= 0 && j < blen) drv_wdata = beats[j];
    else drv_wdata = 16'($urandom);
  endtask

  // Called just after a rising edge with the DUT idle; returns the same way.
  task automatic run_txn(input logic rw, input logic [31:0] addr, input int blen,
                         input int act_lat, input int wlat, input int exp_done, input int hold);
    int cyc, first, done, nburst, spurious;
    drv_addr = addr;
    drv_rw   = rw;
    drv_ce   = 1'b1;
    drv_req  = 1'b1;
    exp_q.delete();
    if (rw == RW_READ) for (int k = 0; k < blen; k++) exp_q.push_back(beats[k]);
    first = -1; done = -1; nburst = 0; cyc = 0;
    drive_wdata(rw, cyc, act_lat, wlat, blen);
    while (done < 0 && cyc < 200) begin
      @(negedge clk);
      if (obs_burst) begin
        if (first < 0) first = cyc;
        nburst++;
        if (rw == RW_READ) begin
          if (exp_q.size() == 0) check("read_beat_count", nburst, blen);
          else check($sformatf("read_data@%0h beat %0d", addr, nburst - 1), obs_rdata,
                     exp_q.pop_front());
        end
      end
      if (obs_done) done = cyc;
      @(posedge clk); #1;
      cyc++;
      drive_wdata(rw, cyc, act_lat, wlat, blen);
    end
    check($sformatf("first_beat_cycle@%0h", addr), first, 1 + act_lat);
    check($sformatf("burst_cycles@%0h", addr), nburst, blen);
    check($sformatf("xfer_done_cycle@%0h", addr), done, exp_done);
    if (rw == RW_READ) check("scoreboard_drained", exp_q.size(), 0);
    spurious = 0;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (obs_burst || obs_done) spurious++;
      @(posedge clk); #1;
    end
    if (hold > 0) check("no_reserve_while_held", spurious, 0);
    drv_req = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    int quiet;

    vecs[0]  = '{RW_WRITE, 32'h0000_0800, 16'h1000, 38, 0};
    vecs[1]  = '{RW_WRITE, 32'h0000_0880, 16'h2000, 38, 0};
    vecs[2]  = '{RW_WRITE, 32'h0000_0840, 16'hA000, 38, 0};
    vecs[3]  = '{RW_READ,  32'h0000_0840, 16'hA000, 36, 5};
    vecs[4]  = '{RW_READ,  32'h0000_0856, 16'hA000, 36, 0};
    vecs[5]  = '{RW_READ,  32'h0000_0800, 16'h1000, 36, 0};
    vecs[6]  = '{RW_READ,  32'h0000_0880, 16'h2000, 36, 0};
    vecs[7]  = '{RW_WRITE, 32'h0000_08C0, 16'h3000, 38, 0};
    vecs[8]  = '{RW_WRITE, 32'h0000_087E, 16'hB000, 38, 0};
    vecs[9]  = '{RW_READ,  32'h0001_8841, 16'hB000, 36, 0};
    vecs[10] = '{RW_READ,  32'h0000_08C0, 16'h3000, 36, 0};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_a_bursting", a_if.data_bursting, 0);
    check("reset_a_done", a_if.xfer_done, 0);
    check("reset_a_rdata", a_if.read_data, 0);
    check("reset_b_bursting", b_if.data_bursting, 0);
    check("reset_b_done", b_if.xfer_done, 0);
    check("reset_b_rdata", b_if.read_data, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    // rw_req with ce low is ignored
    drv_ce = 1'b0; drv_req = 1'b1; drv_rw = RW_READ; drv_addr = 32'h800;
    quiet = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (obs_burst || obs_done) quiet++;
      @(posedge clk); #1;
    end
    check("ce_low_no_response", quiet, 0);
    drv_req = 1'b0;
    @(posedge clk); #1;

    // Table-driven transactions on the default-parameter responder
    for (int v = 0; v < 11; v++) begin
      for (int k = 0; k < 32; k++) beats[k] = vecs[v].base + 16'(k);
      run_txn(vecs[v].rw, vecs[v].addr, 32, 3, 2, vecs[v].exp_done, vecs[v].hold);
    end

    // Reset during write beat 10: beats 0..7 land, the rest keep old page data
    for (int k = 0; k < 32; k++) beats[k] = 16'hC000 + 16'(k);
    drv_addr = 32'h0000_08C0; drv_rw = RW_WRITE; drv_ce = 1'b1; drv_req = 1'b1;
    for (int c = 0; c < 14; c++) begin
      drive_wdata(RW_WRITE, c, 3, 2, 32);
      @(posedge clk); #1;
    end
    check("pre_reset_bursting", obs_burst, 1);
    check("pre_reset_rdata_held", obs_rdata, 16'h3000 + 16'd31);
    reset = 1'b1;
    #1;
    check("async_reset_bursting", obs_burst, 0);
    check("async_reset_done", obs_done, 0);
    check("async_reset_rdata", obs_rdata, 0);
    drv_req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k < 32; k++) beats[k] = (k < 8) ? 16'hC000 + 16'(k) : 16'h3000 + 16'(k);
    run_txn(RW_READ, 32'h0000_08C0, 32, 3, 2, 36, 0);

    // Short-burst configuration: ACT_LAT=1, WRITE_LAT=0, BURST_LEN=8
    sel_b = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 8; k++) beats[k] = 16'h5000 + 16'(3 * k);
    run_txn(RW_WRITE, 32'h0000_0040, 8, 1, 0, 10, 0);
    run_txn(RW_READ,  32'h0000_0040, 8, 1, 0, 10, 0);
    run_txn(RW_READ,  32'h0000_004E, 8, 1, 0, 10, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
